display_controller: RTL and testbench
=====================================

# display_controller

Sequences the 7-segment readout for the processor's I/O path. Arbitrates between two requesters that want a value shown: the processor's OUT instruction and the IN-instruction echo of switch input. It converts the granted 16-bit two's-complement value to sign-plus-BCD with a multi-cycle double-dabble engine and holds the result in display registers. The per-digit 7-segment decoders consume those registers.

## Interface
Parameters:
- `WIDTH`, 16, data width of both request values. Fixed by the processor datapath.
- `CONV_CYCLES`, 16, shift iterations. Must equal `WIDTH`.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `out_req`  in  1  OUT requester wants `out_value` displayed.
- `out_value`  in  16  two's-complement value from the OUT instruction.
- `out_ack`  out  1  one-cycle grant to the OUT requester.
- `in_req`  in  1  IN-echo requester wants `in_value` displayed.
- `in_value`  in  16  two's-complement value from the switch input.
- `in_ack`  out  1  one-cycle grant to the IN requester.
- `busy`  out  1  a conversion is in progress.
- `update`  out  1  one-cycle pulse; the display registers load on this edge.
- `digit_th`, `digit_h`, `digit_t`, `digit_o`  out  4 each  displayed digit codes.
- `neg`  out  1  displayed value is negative.
- `ovf`  out  1  displayed value does not fit the 4-digit field.

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant round-robin: the requester not granted last wins. After reset the pointer favours OUT.
  - Grant actions: assert the matching `*_ack` combinationally in this cycle; latch the sign and the magnitude (`neg ? -value : value`, as 16-bit unsigned, so -32768 gives 32768); clear the 20-bit BCD accumulator; go to SHIFT.
- **SHIFT:** 16 iterations, one per cycle.
  - Each iteration: add 3 to every BCD nibble that is ≥5, then shift {BCD, magnitude} left by one.
  - Counter runs 0..15; leave SHIFT after count 15.
- **DONE:**
  - Assert `update`.
  - Load the display registers as follows, then return to IDLE.
  - Non-negative, magnitude ≤ 9999: `digit_th..digit_o` = 4 BCD digits; `neg`=0; `ovf`=0.
  - Negative, magnitude ≤ 999: `digit_th` = MINUS_CODE (4'hF); `digit_h..digit_o` = 3 BCD digits; `neg`=1; `ovf`=0.
  - Otherwise: all four digits = OVF_CODE (4'hE); `ovf`=1; `neg` = sign.
- **Handshake:**
  - A requester holds `req` and its value stable until it samples `ack`=1.
  - It deasserts `req` the cycle after `ack`, or keeps it high to queue another display.
- **Requests while busy:** not acknowledged; they stay pending until IDLE.
- **Display registers:** hold their value between updates.

## Timing
- Request seen in IDLE at cycle 0: `ack` high in cycle 0.
- `busy` is high cycles 1–17.
- SHIFT occupies cycles 1–16.
- DONE is cycle 17, with `update`=1.
- New digits are visible from cycle 18.
- Earliest next grant is cycle 18.
- Throughput: one display per 18 cycles.
- **Reset** (any state, including mid-SHIFT):
  - Next edge forces IDLE and aborts the conversion.
  - Digits = 0, `neg`=0, `ovf`=0.
  - `busy`, `update`, `out_ack`, `in_ack` = 0.
  - RR pointer favours OUT.
- `ack` is never asserted while `reset` is high.

## Structure
- **Shared package `display_pkg`:** state enum (IDLE/SHIFT/DONE), `MINUS_CODE`=4'hF, `OVF_CODE`=4'hE, `DISP_WIDTH`=16, `BCD_DIGITS`=5. The 7-seg decoders map 4'hF to "−" and 4'hE to "E".
- **Sub-module `bcd_serial`:** double-dabble core with `start`, `magnitude[15:0]`, `done` and `bcd[19:0]`. The controller owns arbitration, the sign and the display registers.

## Test plan
- **Reset:** assert `reset` 2 cycles → all outputs 0; no ack.
- **Positive value:** `out_req` with 1234 → `out_ack` in cycle 0; `update` in cycle 17; digits 1,2,3,4; `neg`=0; `ovf`=0.
- **Negative values:**
  - `in_req` with -45 (16'hFFD3) → digits F,0,4,5 and `neg`=1.
  - -32768 → digits E,E,E,E; `ovf`=1; `neg`=1.
- **Overflow:**
  - 12000 → `ovf`=1; digits E,E,E,E.
  - 9999 → digits 9,9,9,9; `ovf`=0.
- **Simultaneous requests:** both requests held high from reset → grants alternate OUT, IN, OUT at cycles 0, 18, 36. No ack while `busy`.
- **Reset mid-conversion:** reset at cycle 8 of a conversion of 500 → outputs return to reset values; a request held across reset is re-granted on the first IDLE cycle after reset deasserts.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment display path: FSM states,
// special digit codes and the double-dabble nibble adjust.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // The 7-seg decoders render MINUS_CODE as "-" and OVF_CODE as "E".
    localparam logic [3:0] MINUS_CODE = 4'hF;
    localparam logic [3:0] OVF_CODE   = 4'hE;
    localparam int         DISP_WIDTH = 16;
    localparam int         BCD_DIGITS = 5;
    localparam int         BCD_WIDTH  = 4 * BCD_DIGITS;

    function automatic logic [BCD_WIDTH-1:0] dabble_adjust(input logic [BCD_WIDTH-1:0] bcd);
        logic [BCD_WIDTH-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_serial.sv
// Serial double-dabble core: one adjust-and-shift iteration per cycle after start.
// done is high during the final iteration, so bcd is complete on the following cycle.
module bcd_serial
    import display_pkg::*;
#(
    parameter int WIDTH       = DISP_WIDTH,
    parameter int CONV_CYCLES = DISP_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     magnitude,
    output logic                 done,
    output logic [BCD_WIDTH-1:0] bcd
);

    localparam int CNT_W = $clog2(CONV_CYCLES);

    logic [WIDTH-1:0]           mag_r;
    logic [BCD_WIDTH-1:0]       bcd_r;
    logic [CNT_W-1:0]           count_r;
    logic                       running_r;
    logic                       last_s;
    logic [BCD_WIDTH+WIDTH-1:0] shifted_s;

    // Next value of the {bcd, magnitude} shift register and last-iteration flag.
    always_comb begin
        shifted_s = {dabble_adjust(bcd_r), mag_r} << 1;
        last_s    = running_r && (count_r == CNT_W'(CONV_CYCLES - 1));
    end

    // Iteration state: load on start, shift while running, stop after the last count.
    always_ff @(posedge clock) begin
        if (reset) begin
            mag_r     <= '0;
            bcd_r     <= '0;
            count_r   <= '0;
            running_r <= 1'b0;
        end else if (start) begin
            mag_r     <= magnitude;
            bcd_r     <= '0;
            count_r   <= '0;
            running_r <= 1'b1;
        end else if (running_r) begin
            bcd_r     <= shifted_s[BCD_WIDTH+WIDTH-1:WIDTH];
            mag_r     <= shifted_s[WIDTH-1:0];
            count_r   <= count_r + CNT_W'(1);
            running_r <= !last_s;
        end else begin
            mag_r     <= mag_r;
            bcd_r     <= bcd_r;
            count_r   <= count_r;
            running_r <= running_r;
        end
    end

    assign done = last_s;
    assign bcd  = bcd_r;

endmodule

// File: rtl/display_controller.sv
// Arbitrates OUT and IN-echo display requests round-robin, converts the granted
// two's-complement value to sign-plus-BCD and holds it in the display registers.
module display_controller
    import display_pkg::*;
#(
    parameter int WIDTH       = DISP_WIDTH,
    parameter int CONV_CYCLES = DISP_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             out_req,
    input  logic [WIDTH-1:0] out_value,
    output logic             out_ack,
    input  logic             in_req,
    input  logic [WIDTH-1:0] in_value,
    output logic             in_ack,
    output logic             busy,
    output logic             update,
    output logic [3:0]       digit_th,
    output logic [3:0]       digit_h,
    output logic [3:0]       digit_t,
    output logic [3:0]       digit_o,
    output logic             neg,
    output logic             ovf
);

    state_t               state_r;
    state_t               next_s;
    logic                 sign_r;
    logic                 prefer_in_r;
    logic                 start_s;
    logic                 grant_in_s;
    logic [WIDTH-1:0]     sel_value_s;
    logic [WIDTH-1:0]     mag_s;
    logic                 conv_done_s;
    logic [BCD_WIDTH-1:0] bcd_s;
    logic [15:0]          digits_d_s;
    logic                 neg_d_s;
    logic                 ovf_d_s;
    logic [15:0]          digits_r;
    logic                 neg_r;
    logic                 ovf_r;

    bcd_serial #(
        .WIDTH       (WIDTH),
        .CONV_CYCLES (CONV_CYCLES)
    ) u_bcd (
        .clock     (clock),
        .reset     (reset),
        .start     (start_s),
        .magnitude (mag_s),
        .done      (conv_done_s),
        .bcd       (bcd_s)
    );

    // Next-state, grant and ack logic; acks are gated so none escapes during reset.
    always_comb begin
        next_s     = state_r;
        out_ack    = 1'b0;
        in_ack     = 1'b0;
        start_s    = 1'b0;
        grant_in_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!reset && (out_req || in_req)) begin
                    grant_in_s = in_req && (!out_req || prefer_in_r);
                    if (grant_in_s) begin
                        in_ack = 1'b1;
                    end else begin
                        out_ack = 1'b1;
                    end
                    start_s = 1'b1;
                    next_s  = ST_SHIFT;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (conv_done_s) begin
                    next_s = ST_DONE;
                end else begin
                    next_s = ST_SHIFT;
                end
            end
            ST_DONE: next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // Magnitude of the granted value; -32768 wraps to 16'h8000 which is its true magnitude.
    always_comb begin
        sel_value_s = grant_in_s ? in_value : out_value;
        if (sel_value_s[WIDTH-1]) begin
            mag_s = (~sel_value_s) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag_s = sel_value_s;
        end
    end

    // Format the finished BCD into four display digits with sign/overflow handling.
    always_comb begin
        if (!sign_r && (bcd_s[19:16] == 4'd0)) begin
            digits_d_s = bcd_s[15:0];
            neg_d_s    = 1'b0;
            ovf_d_s    = 1'b0;
        end else if (sign_r && (bcd_s[19:12] == 8'd0)) begin
            digits_d_s = {MINUS_CODE, bcd_s[11:0]};
            neg_d_s    = 1'b1;
            ovf_d_s    = 1'b0;
        end else begin
            digits_d_s = {OVF_CODE, OVF_CODE, OVF_CODE, OVF_CODE};
            neg_d_s    = sign_r;
            ovf_d_s    = 1'b1;
        end
    end

    // State, arbitration pointer, latched sign and display registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            sign_r      <= 1'b0;
            prefer_in_r <= 1'b0;
            digits_r    <= 16'h0000;
            neg_r       <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            state_r <= next_s;
            if (start_s) begin
                sign_r      <= sel_value_s[WIDTH-1];
                prefer_in_r <= !grant_in_s;
            end else begin
                sign_r      <= sign_r;
                prefer_in_r <= prefer_in_r;
            end
            if (state_r == ST_DONE) begin
                digits_r <= digits_d_s;
                neg_r    <= neg_d_s;
                ovf_r    <= ovf_d_s;
            end else begin
                digits_r <= digits_r;
                neg_r    <= neg_r;
                ovf_r    <= ovf_r;
            end
        end
    end

    assign busy     = (state_r != ST_IDLE);
    assign update   = (state_r == ST_DONE);
    assign digit_th = digits_r[15:12];
    assign digit_h  = digits_r[11:8];
    assign digit_t  = digits_r[7:4];
    assign digit_o  = digits_r[3:0];
    assign neg      = neg_r;
    assign ovf      = ovf_r;

endmodule

// File: tb/tb_display_controller.sv
// Self-checking bench for display_controller: directed vector table, handshake
// sequences (round-robin, reset mid-conversion) and randomized values vs a model.
module tb_display_controller;

    logic        clock;
    logic        reset;
    logic        out_req;
    logic [15:0] out_value;
    logic        out_ack;
    logic        in_req;
    logic [15:0] in_value;
    logic        in_ack;
    logic        busy;
    logic        update;
    logic [3:0]  digit_th;
    logic [3:0]  digit_h;
    logic [3:0]  digit_t;
    logic [3:0]  digit_o;
    logic        neg;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    display_controller #(.WIDTH(16), .CONV_CYCLES(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .out_req   (out_req),
        .out_value (out_value),
        .out_ack   (out_ack),
        .in_req    (in_req),
        .in_value  (in_value),
        .in_ack    (in_ack),
        .busy      (busy),
        .update    (update),
        .digit_th  (digit_th),
        .digit_h   (digit_h),
        .digit_t   (digit_t),
        .digit_o   (digit_o),
        .neg       (neg),
        .ovf       (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          use_in;
        logic [15:0] value;
        logic [17:0] exp;   // {neg, ovf, th, h, t, o}
    } vec_t;

    vec_t vecs[11];

    function automatic logic [17:0] disp_now();
        return {neg, ovf, digit_th, digit_h, digit_t, digit_o};
    endfunction

    // Reference: what the readout must show for a 16-bit two's-complement value.
    function automatic logic [17:0] model(input logic [15:0] v);
        int s;
        int m;
        logic n;
        s = int'($signed(v));
        n = (s < 0);
        m = n ? -s : s;
        if (!n && m <= 9999)
            return {1'b0, 1'b0, 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
        else if (n && m <= 999)
            return {1'b1, 1'b0, 4'hF, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
        else
            return {n, 1'b1, 16'hEEEE};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycles 1..18 of a conversion; on return we sit at the cycle-18 negedge.
    task automatic follow(input bit drop, input logic [17:0] exp);
        for (int c = 1; c <= 17; c++) begin
            @(posedge clock); #1;
            if (c == 1 && drop) begin
                out_req = 1'b0;
                in_req  = 1'b0;
            end
            @(negedge clock);
            chk("busy_during_conv", {31'd0, busy}, 32'd1);
            chk("no_ack_while_busy", {30'd0, out_ack, in_ack}, 32'd0);
            chk("update_timing", {31'd0, update}, {31'd0, (c == 17)});
        end
        @(negedge clock);
        chk("busy_after_conv", {31'd0, busy}, 32'd0);
        chk("update_after_conv", {31'd0, update}, 32'd0);
        chk("display", {14'd0, disp_now()}, {14'd0, exp});
    endtask

    task automatic run_vec(input bit use_in, input logic [15:0] value, input logic [17:0] exp);
        @(posedge clock); #1;
        if (use_in) begin
            in_req   = 1'b1;
            in_value = value;
        end else begin
            out_req   = 1'b1;
            out_value = value;
        end
        @(negedge clock);
        chk("ack_out", {31'd0, out_ack}, {31'd0, !use_in});
        chk("ack_in", {31'd0, in_ack}, {31'd0, use_in});
        follow(1'b1, exp);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 16'd1234,  {1'b0, 1'b0, 16'h1234}};
        vecs[1]  = '{1'b1, 16'hFFD3,  {1'b1, 1'b0, 16'hF045}};
        vecs[2]  = '{1'b0, 16'h8000,  {1'b1, 1'b1, 16'hEEEE}};
        vecs[3]  = '{1'b1, 16'd12000, {1'b0, 1'b1, 16'hEEEE}};
        vecs[4]  = '{1'b0, 16'd9999,  {1'b0, 1'b0, 16'h9999}};
        vecs[5]  = '{1'b1, 16'd10000, {1'b0, 1'b1, 16'hEEEE}};
        vecs[6]  = '{1'b0, 16'hFC19,  {1'b1, 1'b0, 16'hF999}};
        vecs[7]  = '{1'b1, 16'hFC18,  {1'b1, 1'b1, 16'hEEEE}};
        vecs[8]  = '{1'b0, 16'd0,     {1'b0, 1'b0, 16'h0000}};
        vecs[9]  = '{1'b1, 16'h7FFF,  {1'b0, 1'b1, 16'hEEEE}};
        vecs[10] = '{1'b0, 16'hFFFF,  {1'b1, 1'b0, 16'hF001}};

        reset     = 1'b1;
        out_req   = 1'b0;
        in_req    = 1'b0;
        out_value = 16'd0;
        in_value  = 16'd0;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_display", {14'd0, disp_now()}, 32'd0);
        chk("reset_flags", {28'd0, busy, update, out_ack, in_ack}, 32'd0);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i].use_in, vecs[i].value, vecs[i].exp);
        end

        // Both requesters held from reset: grants OUT, IN, OUT at cycles 0, 18, 36
        @(posedge clock); #1;
        reset     = 1'b1;
        out_req   = 1'b1;
        in_req    = 1'b1;
        out_value = 16'd100;
        in_value  = 16'hFFF9;
        repeat (2) begin
            @(negedge clock);
            chk("no_ack_in_reset", {30'd0, out_ack, in_ack}, 32'd0);
            @(posedge clock);
        end
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rr_grant0", {30'd0, out_ack, in_ack}, 32'd2);
        follow(1'b0, {1'b0, 1'b0, 16'h0100});
        chk("rr_grant1", {30'd0, out_ack, in_ack}, 32'd1);
        follow(1'b0, {1'b1, 1'b0, 16'hF007});
        chk("rr_grant2", {30'd0, out_ack, in_ack}, 32'd2);
        follow(1'b1, {1'b0, 1'b0, 16'h0100});

        // Reset at cycle 8 of a conversion of 500, with an IN request held across it
        @(posedge clock); #1;
        out_req   = 1'b1;
        out_value = 16'd500;
        @(negedge clock);
        chk("mid_ack_out", {31'd0, out_ack}, 32'd1);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clock); #1;
            if (c == 1) out_req = 1'b0;
            if (c == 8) begin
                reset    = 1'b1;
                in_req   = 1'b1;
                in_value = 16'd321;
            end
            @(negedge clock);
            chk("mid_busy", {31'd0, busy}, 32'd1);
        end
        chk("mid_no_ack", {30'd0, out_ack, in_ack}, 32'd0);
        @(negedge clock);
        chk("mid_reset_flags", {28'd0, busy, update, out_ack, in_ack}, 32'd0);
        chk("mid_reset_display", {14'd0, disp_now()}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("regrant_after_reset", {30'd0, out_ack, in_ack}, 32'd1);
        follow(1'b1, {1'b0, 1'b0, 16'h0321});

        // Randomized values against the reference model
        for (int i = 0; i < 24; i++) begin
            bit          u;
            logic [15:0] v;
            u = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       v = 16'($urandom_range(0, 9999));
                1:       v = 16'(-int'($urandom_range(0, 999)));
                default: v = 16'($urandom);
            endcase
            run_vec(u, v, model(v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
